wavepool_decode_arbiter: RTL

- Round-robin arbiter that picks which wavefront's buffered instruction is sent into the decode stage each cycle.
- Locks the arbitration onto a single wavefront whenever decode reports that the word just received is the first half of a 64-bit instruction or literal (half_rqd/half_wfid), so the second word follows with no interleaving.
- Sits between the wavepool instruction buffers and the decode pipeline flops. The wavepool muxes instruction, pc, and register bases using the grant outputs.

---
 rtl/wavepool_decode_arbiter_pkg.sv | 13 +
 rtl/wavepool_decode_arbiter_if.sv | 30 +++
 rtl/wavepool_decode_arbiter_rr_prio_enc.sv | 44 ++++
 rtl/wavepool_decode_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/wavepool_decode_arbiter_pkg.sv
// Shared definitions for the wavepool-to-decode arbiter: default sizing
// and the arbiter FSM state encoding.
package wavepool_decode_arbiter_pkg;

  localparam int NUM_WF_DEF = 40;
  localparam int WFID_W_DEF = 6;

  typedef enum logic {
    ARB       = 1'b0,
    HALF_LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wavepool_decode_arbiter_if.sv
// Request/grant bundle between the wavepool buffers, decode and the arbiter.
// The master side is the wavepool/decode pair; the arbiter is the slave.
interface wavepool_decode_arbiter_if
  import wavepool_decode_arbiter_pkg::*;
#(
  parameter int NUM_WF = NUM_WF_DEF,
  parameter int WFID_W = WFID_W_DEF
);

  logic [NUM_WF-1:0] wf_ready;
  logic              decode_stall;
  logic              half_rqd;
  logic [WFID_W-1:0] half_wfid;
  logic              grant_valid;
  logic [WFID_W-1:0] grant_wfid;
  logic [NUM_WF-1:0] grant_onehot;
  logic              grant_is_half;
  logic              lock_active;

  modport master (
    output wf_ready, decode_stall, half_rqd, half_wfid,
    input  grant_valid, grant_wfid, grant_onehot, grant_is_half, lock_active
  );

  modport slave (
    input  wf_ready, decode_stall, half_rqd, half_wfid,
    output grant_valid, grant_wfid, grant_onehot, grant_is_half, lock_active
  );

endinterface

// File: rtl/wavepool_decode_arbiter_rr_prio_enc.sv
// Round-robin priority encoder: finds the first requester strictly after
// i_ptr, wrapping around, by priority-encoding a doubled and masked request.
module wavepool_decode_arbiter_rr_prio_enc
  import wavepool_decode_arbiter_pkg::*;
#(
  parameter int NUM_WF = NUM_WF_DEF,
  parameter int WFID_W = WFID_W_DEF
)
(
  input  logic [NUM_WF-1:0] i_req,
  input  logic [WFID_W-1:0] i_ptr,
  output logic              o_found,
  output logic [WFID_W-1:0] o_wfid
);

  localparam int IDX_W = $clog2(2 * NUM_WF);

  logic [2*NUM_WF-1:0] w_dbl;
  logic [2*NUM_WF-1:0] w_masked;
  logic [IDX_W-1:0]    w_idx;

  assign w_dbl = {i_req, i_req};

  // Window (ptr, ptr+NUM_WF] of the doubled vector covers every slot once,
  // with ptr itself landing last; scanning downward leaves the lowest hit.
  always_comb begin
    w_masked = '0;
    o_found  = 1'b0;
    w_idx    = '0;
    for (int j = 0; j < 2 * NUM_WF; j++) begin
      w_masked[j] = w_dbl[j] && (j > int'(i_ptr)) && (j <= int'(i_ptr) + NUM_WF);
    end
    for (int j = 2 * NUM_WF - 1; j >= 0; j--) begin
      if (w_masked[j]) begin
        o_found = 1'b1;
        w_idx   = IDX_W'(j);
      end
    end
  end

  assign o_wfid = (w_idx >= IDX_W'(NUM_WF)) ? WFID_W'(w_idx - IDX_W'(NUM_WF))
                                             : WFID_W'(w_idx);

endmodule

// File: rtl/wavepool_decode_arbiter.sv
// Selects which wavefront feeds decode each cycle: round-robin normally,
// pinned to one wavefront while the second half of a 64-bit word is owed.
module wavepool_decode_arbiter
  import wavepool_decode_arbiter_pkg::*;
#(
  parameter int NUM_WF = NUM_WF_DEF,
  parameter int WFID_W = WFID_W_DEF
)
(
  input  logic                          clk,
  input  logic                          rst_n,
  wavepool_decode_arbiter_if.slave      io_arb
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [WFID_W-1:0] r_rr_ptr;
  logic [WFID_W-1:0] w_rr_ptr_nxt;
  logic [WFID_W-1:0] r_lock_wfid;
  logic [WFID_W-1:0] w_lock_wfid_nxt;

  logic              w_eff_lock;
  logic [WFID_W-1:0] w_eff_wfid;
  logic              w_eff_ready;
  logic              w_rr_found;
  logic [WFID_W-1:0] w_rr_wfid;

  logic              w_grant_valid;
  logic [WFID_W-1:0] w_grant_wfid;
  logic              w_grant_half;
  logic [NUM_WF-1:0] w_grant_onehot;

  wavepool_decode_arbiter_rr_prio_enc #(
    .NUM_WF (NUM_WF),
    .WFID_W (WFID_W)
  ) u_rr_prio_enc (
    .i_req   (io_arb.wf_ready),
    .i_ptr   (r_rr_ptr),
    .o_found (w_rr_found),
    .o_wfid  (w_rr_wfid)
  );

  // half_rqd arrives in the same cycle it must steer the grant, so the lock
  // is the union of the registered lock and the live request.
  assign w_eff_lock = (r_state == HALF_LOCK) || io_arb.half_rqd;
  assign w_eff_wfid = io_arb.half_rqd ? io_arb.half_wfid : r_lock_wfid;

  always_comb begin
    w_eff_ready = 1'b0;
    for (int i = 0; i < NUM_WF; i++) begin
      if (WFID_W'(i) == w_eff_wfid) begin
        w_eff_ready = io_arb.wf_ready[i];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_lock_wfid_nxt = r_lock_wfid;
    w_grant_valid   = 1'b0;
    w_grant_wfid    = '0;
    w_grant_half    = 1'b0;
    if (w_eff_lock) begin
      if (!io_arb.decode_stall && w_eff_ready) begin
        w_grant_valid = 1'b1;
        w_grant_wfid  = w_eff_wfid;
        w_grant_half  = 1'b1;
        w_state_nxt   = ARB;
      end else begin
        w_state_nxt     = HALF_LOCK;
        w_lock_wfid_nxt = w_eff_wfid;
      end
    end else if (!io_arb.decode_stall && w_rr_found) begin
      w_grant_valid = 1'b1;
      w_grant_wfid  = w_rr_wfid;
      w_rr_ptr_nxt  = w_rr_wfid;
    end
  end

  always_comb begin
    w_grant_onehot = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      w_grant_onehot[i] = w_grant_valid && (WFID_W'(i) == w_grant_wfid);
    end
  end

  // Reset leaves wf 0 first in line: the search starts just after the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB;
      r_rr_ptr    <= WFID_W'(NUM_WF - 1);
      r_lock_wfid <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_lock_wfid <= w_lock_wfid_nxt;
    end
  end

  assign io_arb.grant_valid   = w_grant_valid & rst_n;
  assign io_arb.grant_wfid    = rst_n ? w_grant_wfid : '0;
  assign io_arb.grant_onehot  = w_grant_onehot & {NUM_WF{rst_n}};
  assign io_arb.grant_is_half = w_grant_half & rst_n;
  assign io_arb.lock_active   = (r_state == HALF_LOCK) & rst_n;

  a_no_rqd_in_lock: assert property (@(posedge clk) disable iff (!rst_n)
    !(io_arb.half_rqd && (r_state == HALF_LOCK)));

  a_half_wfid_range: assert property (@(posedge clk) disable iff (!rst_n)
    io_arb.half_rqd |-> (int'(io_arb.half_wfid) < NUM_WF));

endmodule
